bottling_display_scan: RTL and testbench

// - Downstream of the bottling-line counters: takes four BCD count digits and drives the

---
 rtl/bottling_pkg.sv | 48 ++++
 rtl/bcd_to_seg.sv | 34 +++
 rtl/bottling_display_scan.sv | 156 +++++++++++++++
 tb/tb_bottling_display_scan.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bottling_pkg.sv
// ============================================================================
// Module  : bottling_pkg
// Brief   : Shared constants for the bottling-line 7-segment display scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bottling_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment patterns, active-high, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [3:0] DIGIT_EN0 = 4'b0001;
  localparam logic [3:0] DIGIT_EN1 = 4'b0010;
  localparam logic [3:0] DIGIT_EN2 = 4'b0100;
  localparam logic [3:0] DIGIT_EN3 = 4'b1000;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } blink_phase_e;

  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    logic [3:0] en;
    case (idx)
      2'd0:    en = DIGIT_EN0;
      2'd1:    en = DIGIT_EN1;
      2'd2:    en = DIGIT_EN2;
      default: en = DIGIT_EN3;
    endcase
    return en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module  : bcd_to_seg
// Brief   : Combinational BCD nibble to 7-segment pattern; 10-15 show a dash.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
  import bottling_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bottling_display_scan.sv
// ============================================================================
// Module  : bottling_display_scan
// Brief   : Registered 4-digit multiplexed 7-segment scanner with tear-free
//           update, anti-ghost guard, leading-zero blanking and alarm blink.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bottling_display_scan
  import bottling_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int GUARD        = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] digit_in_i,
  input  logic        upd_i,
  input  logic        blank_lz_i,
  input  logic        alarm_i,
  output logic [6:0]  display_o,
  output logic [3:0]  digitos_o,
  output logic        frame_tick_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END = PW'(GUARD);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(NUM_DIGITS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   staging_q, staging_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e  phase_q, phase_d;
  logic          wrap_q, wrap_d;
  logic [6:0]    display_q, display_d;
  logic [3:0]    digitos_q, digitos_d;
  logic          frame_tick_q, frame_tick_d;

  logic          w_tick;
  logic          w_boundary;
  logic          w_blank;
  logic          w_guard;
  logic          w_show;
  logic [3:0]    w_nibble;
  logic [3:0]    w_lz;
  logic [6:0]    w_seg;

  assign w_tick     = (presc_q == PRESC_MAX);
  assign w_boundary = w_tick && (idx_q == LAST_IDX);
  assign w_nibble   = shadow_q[{idx_q, 2'b00} +: 4];

  // w_lz[k]: nibble k and every higher nibble are zero; digit0 is never blanked
  assign w_lz[NUM_DIGITS-1] = (shadow_q[4*(NUM_DIGITS-1) +: 4] == 4'd0);
  for (genvar k = NUM_DIGITS - 2; k >= 1; k--) begin : g_lz
    assign w_lz[k] = w_lz[k+1] && (shadow_q[4*k +: 4] == 4'd0);
  end
  assign w_lz[0] = 1'b0;

  assign w_blank = blank_lz_i && w_lz[idx_q];
  assign w_guard = (presc_q < GUARD_END);
  // Dropping alarm restores enables on the very next registered output
  assign w_show  = (phase_q == PHASE_ON) || !alarm_i;

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (w_nibble),
    .seg_o (w_seg)
  );

  always_comb begin
    presc_d      = presc_q + 1'b1;
    idx_d        = idx_q;
    staging_d    = staging_q;
    pending_d    = pending_q;
    shadow_d     = shadow_q;
    blink_cnt_d  = blink_cnt_q;
    phase_d      = phase_q;
    wrap_d       = w_boundary;
    display_d    = w_blank ? 7'd0 : w_seg;
    digitos_d    = (!w_blank && !w_guard && w_show) ? digit_enable(idx_q) : 4'd0;
    frame_tick_d = wrap_q;

    if (w_tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end

    if (upd_i) begin
      staging_d = digit_in_i;
      pending_d = 1'b1;
    end

    // Shadow only moves at the frame boundary so a frame is never torn
    if (w_boundary) begin
      if (upd_i) begin
        shadow_d = digit_in_i;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
      pending_d = 1'b0;
    end

    if (!alarm_i) begin
      blink_cnt_d = '0;
      phase_d     = PHASE_ON;
    end else if (w_boundary) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q      <= '0;
      idx_q        <= '0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= PHASE_ON;
      wrap_q       <= 1'b0;
      display_q    <= '0;
      digitos_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      wrap_q       <= wrap_d;
      display_q    <= display_d;
      digitos_q    <= digitos_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign display_o    = display_q;
  assign digitos_o    = digitos_q;
  assign frame_tick_o = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_bottling_display_scan.sv
// ============================================================================
// Module  : tb_bottling_display_scan
// Brief   : Directed self-checking bench for bottling_display_scan.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bottling_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digit_in = 16'h0000;
  logic        upd = 1'b0;
  logic        blank_lz = 1'b0;
  logic        alarm = 1'b0;
  logic [6:0]  display;
  logic [3:0]  digitos;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  bottling_display_scan #(
    .SCAN_DIV     (8),
    .GUARD        (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .digit_in_i   (digit_in),
    .upd_i        (upd),
    .blank_lz_i   (blank_lz),
    .alarm_i      (alarm),
    .display_o    (display),
    .digitos_o    (digitos),
    .frame_tick_o (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if ($countones(digitos) > 1) begin
        miscompares++;
        $display("FAIL onehot t=%0t got digitos=%b want at most one bit", $time, digitos);
      end
    end
  end

  task automatic test_reset();
    logic [11:0] got;
    upd      = 1'b1;
    digit_in = 16'hFFFF;
    #2 rst = 1'b1;
    #1;
    got = {display, digitos, frame_tick};
    vectors++;
    if (got !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_async got %h want 000", got);
    end
    repeat (3) @(posedge clk);
    #1;
    got = {display, digitos, frame_tick};
    vectors++;
    if (got !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_hold got %h want 000", got);
    end
    upd      = 1'b0;
    digit_in = 16'h0000;
    rst      = 1'b0;
    k        = 0;
  endtask

  task automatic test_scan();
    logic [15:0] v;
    logic [11:0] got, exp;
    int s, p;
    for (int f = 0; f < 2; f++) begin
      v = (f == 0) ? 16'h0000 : 16'h1234;
      for (int c = 0; c < 32; c++) begin
        step();
        s = c / 8;
        p = c % 8;
        exp = {seg(v[4*s +: 4]), (p >= 2) ? (4'b0001 << s) : 4'b0000, (c == 0 && f == 1)};
        got = {display, digitos, frame_tick};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL scan k=%0d got %h want %h", k, got, exp);
        end
        upd = (f == 0 && c == 5);
        if (upd) digit_in = 16'h1234;
      end
    end
  endtask

  task automatic test_blank();
    logic [15:0] v;
    logic [3:0]  bl;
    logic [11:0] got, exp;
    int s, p;
    blank_lz = 1'b1;
    for (int f = 0; f < 3; f++) begin
      v  = (f == 0) ? 16'h1234 : (f == 1) ? 16'h0050 : 16'h0000;
      bl = (f == 0) ? 4'b0000  : (f == 1) ? 4'b1100  : 4'b1110;
      for (int c = 0; c < 32; c++) begin
        step();
        s = c / 8;
        p = c % 8;
        exp = {bl[s] ? 7'h00 : seg(v[4*s +: 4]),
               (!bl[s] && p >= 2) ? (4'b0001 << s) : 4'b0000, (c == 0)};
        got = {display, digitos, frame_tick};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL blank_lz k=%0d got %h want %h", k, got, exp);
        end
        upd = (f == 0 && c == 0) || (f == 1 && c == 10);
        if (upd) digit_in = (f == 0) ? 16'h0050 : 16'h0000;
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_tear_free();
    logic [15:0] v;
    logic [11:0] got, exp;
    int s, p;
    for (int f = 0; f < 3; f++) begin
      v = (f == 0) ? 16'h0000 : (f == 1) ? 16'h2222 : 16'h9A87;
      for (int c = 0; c < 32; c++) begin
        step();
        s = c / 8;
        p = c % 8;
        exp = {seg(v[4*s +: 4]), (p >= 2) ? (4'b0001 << s) : 4'b0000, (c == 0)};
        got = {display, digitos, frame_tick};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL tear_free k=%0d got %h want %h", k, got, exp);
        end
        upd = 1'b0;
        if (f == 0 && c == 12) begin upd = 1'b1; digit_in = 16'h1111; end
        if (f == 0 && c == 15) begin upd = 1'b1; digit_in = 16'h2222; end
        if (f == 1 && c == 30) begin upd = 1'b1; digit_in = 16'h9A87; end
      end
    end
  endtask

  task automatic test_alarm_blink();
    logic [11:0] got, exp;
    logic        on;
    int s, p;
    alarm = 1'b1;
    for (int f = 0; f < 7; f++) begin
      for (int c = 0; c < 32; c++) begin
        step();
        s  = c / 8;
        p  = c % 8;
        on = !(f == 2 || f == 3 || (f == 6 && c <= 12));
        exp = {seg(16'h9A87 >> (4*s)), (on && p >= 2) ? (4'b0001 << s) : 4'b0000, (c == 0)};
        got = {display, digitos, frame_tick};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL alarm_blink k=%0d got %h want %h", k, got, exp);
        end
        if (f == 6 && c == 12) alarm = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] got, exp;
    int s, p, cc;
    for (int c = 0; c <= 18; c++) begin
      step();
      s = c / 8;
      p = c % 8;
      exp = {seg(16'h9A87 >> (4*s)), (p >= 2) ? (4'b0001 << s) : 4'b0000, (c == 0)};
      got = {display, digitos, frame_tick};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL pre_reset k=%0d got %h want %h", k, got, exp);
      end
    end
    #1 rst = 1'b1;
    #1;
    got = {display, digitos, frame_tick};
    vectors++;
    if (got !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset got %h want 000", got);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    k   = 0;
    for (int c = 0; c < 33; c++) begin
      step();
      cc = c % 32;
      s  = cc / 8;
      p  = cc % 8;
      exp = {7'h3F, (p >= 2) ? (4'b0001 << s) : 4'b0000, (c == 32)};
      got = {display, digitos, frame_tick};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL post_reset k=%0d got %h want %h", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_tear_free();
    test_alarm_blink();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
